// File: rtl/dual_port_ram_v2.sv
// Single-clock true dual-port RAM with byte enables and deterministic same-address arbitration.
// Also provides out-of-range flagging, an optional output register and a post-reset clear sequencer.
module dual_port_ram_v2 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8,
  parameter int READ_MODE  = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      chipe_a,
  input  logic                      chipe_b,
  input  logic                      wre_a,
  input  logic                      wre_b,
  input  logic [DATA_WIDTH/8-1:0]   be_a,
  input  logic [DATA_WIDTH/8-1:0]   be_b,
  input  logic [ADDR_WIDTH-1:0]     addr_a,
  input  logic [ADDR_WIDTH-1:0]     addr_b,
  input  logic [DATA_WIDTH-1:0]     data_in_a,
  input  logic [DATA_WIDTH-1:0]     data_in_b,
  output logic [DATA_WIDTH-1:0]     data_out_a,
  output logic [DATA_WIDTH-1:0]     data_out_b,
  output logic                      valid_a,
  output logic                      valid_b,
  output logic                      addr_err_a,
  output logic                      addr_err_b,
  output logic                      collision,
  output logic                      init_busy
);

  localparam int                    LANES     = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   clr_ptr_reg;
  logic                    busy_reg;
  logic [DATA_WIDTH-1:0]   ram [DEPTH];

  logic                    acc_a, acc_b;
  logic                    in_a, in_b;
  logic                    same_addr;
  logic [DATA_WIDTH-1:0]   old_a, old_b;
  logic [DATA_WIDTH-1:0]   own_a, own_b, both_word;
  logic [DATA_WIDTH-1:0]   final_a, final_b;
  logic [DATA_WIDTH-1:0]   res_a, res_b;
  logic                    ram_we_a, ram_we_b;
  logic                    coll_now;

  // Stage-1 result registers (first registered view of each access)
  logic [DATA_WIDTH-1:0]   data_a_reg, data_b_reg;
  logic                    valid_a_reg, valid_b_reg;
  logic                    err_a_reg, err_b_reg;
  logic                    coll_reg;

  assign acc_a     = (state_reg == READY) && chipe_a;
  assign acc_b     = (state_reg == READY) && chipe_b;
  assign in_a      = {1'b0, addr_a} < DEPTH_W;
  assign in_b      = {1'b0, addr_b} < DEPTH_W;
  assign same_addr = acc_a && acc_b && in_a && in_b && (addr_a == addr_b);
  assign coll_now  = same_addr && (wre_a || wre_b);

  assign old_a = in_a ? ram[addr_a] : '0;
  assign old_b = in_b ? ram[addr_b] : '0;

  // Per-lane merge: own_x is a port acting alone, both_word is the A-over-B merge on a shared address
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic lane_wa, lane_wb;
      assign lane_wa = acc_a && in_a && wre_a && be_a[gi];
      assign lane_wb = acc_b && in_b && wre_b && be_b[gi];
      assign own_a[8*gi +: 8]     = lane_wa ? data_in_a[8*gi +: 8] : old_a[8*gi +: 8];
      assign own_b[8*gi +: 8]     = lane_wb ? data_in_b[8*gi +: 8] : old_b[8*gi +: 8];
      assign both_word[8*gi +: 8] = lane_wa ? data_in_a[8*gi +: 8] :
                                    (lane_wb ? data_in_b[8*gi +: 8] : old_a[8*gi +: 8]);
    end
  endgenerate

  assign final_a = same_addr ? both_word : own_a;
  assign final_b = same_addr ? both_word : own_b;

  // For a plain read final_x equals old_x, so one expression covers reads and writes
  assign res_a = in_a ? ((READ_MODE != 0) ? final_a : old_a) : '0;
  assign res_b = in_b ? ((READ_MODE != 0) ? final_b : old_b) : '0;

  // On a shared address port A commits the merged word once; B stays off that row
  assign ram_we_a = acc_a && in_a && (wre_a || (same_addr && wre_b));
  assign ram_we_b = acc_b && in_b && wre_b && !same_addr;

  always_ff @(posedge clk) begin
    if (nrst) begin
      if (state_reg == CLEAR) begin
        ram[clr_ptr_reg] <= '0;
      end else begin
        if (ram_we_a) ram[addr_a] <= final_a;
        if (ram_we_b) ram[addr_b] <= final_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg   <= CLEAR;
      clr_ptr_reg <= '0;
      busy_reg    <= 1'b1;
      data_a_reg  <= '0;
      data_b_reg  <= '0;
      valid_a_reg <= 1'b0;
      valid_b_reg <= 1'b0;
      err_a_reg   <= 1'b0;
      err_b_reg   <= 1'b0;
      coll_reg    <= 1'b0;
    end else begin
      case (state_reg)
        CLEAR: begin
          clr_ptr_reg <= clr_ptr_reg + 1'b1;
          valid_a_reg <= 1'b0;
          valid_b_reg <= 1'b0;
          err_a_reg   <= 1'b0;
          err_b_reg   <= 1'b0;
          coll_reg    <= 1'b0;
          if (clr_ptr_reg == LAST_ADDR) begin
            state_reg <= READY;
            busy_reg  <= 1'b0;
          end
        end
        READY: begin
          valid_a_reg <= acc_a;
          valid_b_reg <= acc_b;
          err_a_reg   <= acc_a && !in_a;
          err_b_reg   <= acc_b && !in_b;
          coll_reg    <= coll_now;
          if (acc_a) data_a_reg <= res_a;
          if (acc_b) data_b_reg <= res_b;
        end
        default: state_reg <= CLEAR;
      endcase
    end
  end

  assign init_busy = busy_reg;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] data_a_pipe, data_b_pipe;
      logic                  valid_a_pipe, valid_b_pipe;
      logic                  err_a_pipe, err_b_pipe;
      logic                  coll_pipe;

      always_ff @(posedge clk) begin
        if (!nrst) begin
          data_a_pipe  <= '0;
          data_b_pipe  <= '0;
          valid_a_pipe <= 1'b0;
          valid_b_pipe <= 1'b0;
          err_a_pipe   <= 1'b0;
          err_b_pipe   <= 1'b0;
          coll_pipe    <= 1'b0;
        end else begin
          data_a_pipe  <= data_a_reg;
          data_b_pipe  <= data_b_reg;
          valid_a_pipe <= valid_a_reg;
          valid_b_pipe <= valid_b_reg;
          err_a_pipe   <= err_a_reg;
          err_b_pipe   <= err_b_reg;
          coll_pipe    <= coll_reg;
        end
      end

      assign data_out_a = data_a_pipe;
      assign data_out_b = data_b_pipe;
      assign valid_a    = valid_a_pipe;
      assign valid_b    = valid_b_pipe;
      assign addr_err_a = err_a_pipe;
      assign addr_err_b = err_b_pipe;
      assign collision  = coll_pipe;
    end else begin : g_no_out_reg
      assign data_out_a = data_a_reg;
      assign data_out_b = data_b_reg;
      assign valid_a    = valid_a_reg;
      assign valid_b    = valid_b_reg;
      assign addr_err_a = err_a_reg;
      assign addr_err_b = err_b_reg;
      assign collision  = coll_reg;
    end
  endgenerate

endmodule

// File: tb/tb_dual_port_ram_v2.sv
// Directed bench: two instances share stimulus, one read-first/1-cycle, one write-first/2-cycle.
module tb_dual_port_ram_v2;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        chipe_a = 1'b0, chipe_b = 1'b0;
  logic        wre_a = 1'b0, wre_b = 1'b0;
  logic [1:0]  be_a = '0, be_b = '0;
  logic [2:0]  addr_a = '0, addr_b = '0;
  logic [15:0] data_in_a = '0, data_in_b = '0;

  logic [15:0] d0_out_a, d0_out_b, d1_out_a, d1_out_b;
  logic        d0_va, d0_vb, d0_ea, d0_eb, d0_coll, d0_busy;
  logic        d1_va, d1_vb, d1_ea, d1_eb, d1_coll, d1_busy;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  // Held data_out values and the one-step-delayed expectations for the registered-output instance
  logic [15:0] h0a = '0, h0b = '0, h1a = '0, h1b = '0;
  logic [15:0] p_a = '0, p_b = '0;
  logic        p_va = 1'b0, p_vb = 1'b0, p_ea = 1'b0, p_eb = 1'b0, p_coll = 1'b0;

  always #5 clk = ~clk;

  dual_port_ram_v2 #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .DEPTH(6), .READ_MODE(0), .OUT_REG(0)) dut0 (
    .clk(clk), .nrst(nrst), .chipe_a(chipe_a), .chipe_b(chipe_b), .wre_a(wre_a), .wre_b(wre_b),
    .be_a(be_a), .be_b(be_b), .addr_a(addr_a), .addr_b(addr_b),
    .data_in_a(data_in_a), .data_in_b(data_in_b), .data_out_a(d0_out_a), .data_out_b(d0_out_b),
    .valid_a(d0_va), .valid_b(d0_vb), .addr_err_a(d0_ea), .addr_err_b(d0_eb),
    .collision(d0_coll), .init_busy(d0_busy));

  dual_port_ram_v2 #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .DEPTH(6), .READ_MODE(1), .OUT_REG(1)) dut1 (
    .clk(clk), .nrst(nrst), .chipe_a(chipe_a), .chipe_b(chipe_b), .wre_a(wre_a), .wre_b(wre_b),
    .be_a(be_a), .be_b(be_b), .addr_a(addr_a), .addr_b(addr_b),
    .data_in_a(data_in_a), .data_in_b(data_in_b), .data_out_a(d1_out_a), .data_out_b(d1_out_b),
    .valid_a(d1_va), .valid_b(d1_vb), .addr_err_a(d1_ea), .addr_err_b(d1_eb),
    .collision(d1_coll), .init_busy(d1_busy));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %h expected %h", tag, step_no, obs, exp);
    end
  endtask

  task automatic req_a(input logic c, input logic w, input logic [1:0] be,
                       input logic [2:0] ad, input logic [15:0] d);
    chipe_a = c; wre_a = w; be_a = be; addr_a = ad; data_in_a = d;
  endtask

  task automatic req_b(input logic c, input logic w, input logic [1:0] be,
                       input logic [2:0] ad, input logic [15:0] d);
    chipe_b = c; wre_b = w; be_b = be; addr_b = ad; data_in_b = d;
  endtask

  // One clock: ea0/eb0 are read-first results, ea1/eb1 write-first results of this step's request
  task automatic step(input logic [15:0] ea0, input logic [15:0] eb0,
                      input logic [15:0] ea1, input logic [15:0] eb1,
                      input logic eva, input logic evb, input logic eea, input logic eeb,
                      input logic ecoll, input logic ebusy);
    @(posedge clk);
    #1;
    step_no++;
    if (eva) h0a = ea0;
    if (evb) h0b = eb0;
    check("d0_data_a", d0_out_a, h0a);
    check("d0_data_b", d0_out_b, h0b);
    check("d0_valid_a", d0_va, eva);
    check("d0_valid_b", d0_vb, evb);
    check("d0_err_a", d0_ea, eea);
    check("d0_err_b", d0_eb, eeb);
    check("d0_coll", d0_coll, ecoll);
    check("d0_busy", d0_busy, ebusy);
    if (p_va) h1a = p_a;
    if (p_vb) h1b = p_b;
    check("d1_data_a", d1_out_a, h1a);
    check("d1_data_b", d1_out_b, h1b);
    check("d1_valid_a", d1_va, p_va);
    check("d1_valid_b", d1_vb, p_vb);
    check("d1_err_a", d1_ea, p_ea);
    check("d1_err_b", d1_eb, p_eb);
    check("d1_coll", d1_coll, p_coll);
    check("d1_busy", d1_busy, ebusy);
    p_a = ea1; p_b = eb1; p_va = eva; p_vb = evb; p_ea = eea; p_eb = eeb; p_coll = ecoll;
    $display("step %0d: A=%h/%b B=%h/%b coll=%b busy=%b", step_no, d0_out_a, d0_va,
             d0_out_b, d0_vb, d0_coll, d0_busy);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    @(posedge clk);
    #1;
    step_no++;
    check("rst_d0_data_a", d0_out_a, 16'h0);
    check("rst_d0_data_b", d0_out_b, 16'h0);
    check("rst_d0_valid", {d0_va, d0_vb, d0_ea, d0_eb, d0_coll}, 5'b0);
    check("rst_d0_busy", d0_busy, 1'b1);
    check("rst_d1_data_a", d1_out_a, 16'h0);
    check("rst_d1_data_b", d1_out_b, 16'h0);
    check("rst_d1_valid", {d1_va, d1_vb, d1_ea, d1_eb, d1_coll}, 5'b0);
    check("rst_d1_busy", d1_busy, 1'b1);
    h0a = '0; h0b = '0; h1a = '0; h1b = '0;
    p_va = 1'b0; p_vb = 1'b0; p_ea = 1'b0; p_eb = 1'b0; p_coll = 1'b0;
    $display("step %0d: reset busy=%b valid=%b%b", step_no, d0_busy, d0_va, d1_va);
    nrst = 1'b1;
  endtask

  // Six clear edges with a request pending on A that must be ignored
  task automatic run_clear();
    req_a(1'b1, 1'b0, 2'b00, 3'd0, 16'h0);
    req_b(1'b0, 1'b0, 2'b00, 3'd0, 16'h0);
    for (int i = 0; i < 6; i++) begin
      step(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (i < 5) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    do_reset();
    run_clear();

    // Every word reads back zero after the clear
    for (int i = 0; i < 6; i++) begin
      req_a(1'b1, 1'b0, 2'b00, 3'(i), 16'h0);
      req_b(1'b1, 1'b0, 2'b00, 3'(5 - i), 16'h0);
      step(16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Byte-enable merge on address 3
    req_a(1'b1, 1'b1, 2'b11, 3'd3, 16'hBEEF); req_b(1'b0, 1'b0, 2'b00, 3'd0, 16'h0);
    step(16'h0000, 16'h0, 16'hBEEF, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    req_a(1'b1, 1'b1, 2'b01, 3'd3, 16'h1234);
    step(16'hBEEF, 16'h0, 16'hBE34, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    req_a(1'b0, 1'b0, 2'b00, 3'd0, 16'h0); req_b(1'b1, 1'b0, 2'b00, 3'd3, 16'h0);
    step(16'h0, 16'hBE34, 16'h0, 16'hBE34, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    req_b(1'b0, 1'b0, 2'b00, 3'd0, 16'h0);
    step(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Write/write collisions on address 5
    req_a(1'b1, 1'b1, 2'b01, 3'd5, 16'h00AA); req_b(1'b1, 1'b1, 2'b01, 3'd5, 16'h0055);
    step(16'h0000, 16'h0000, 16'h00AA, 16'h00AA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    req_a(1'b1, 1'b1, 2'b10, 3'd5, 16'h11CC); req_b(1'b1, 1'b1, 2'b11, 3'd5, 16'h2233);
    step(16'h00AA, 16'h00AA, 16'h1133, 16'h1133, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    req_a(1'b1, 1'b0, 2'b00, 3'd5, 16'h0); req_b(1'b1, 1'b0, 2'b00, 3'd5, 16'h0);
    step(16'h1133, 16'h1133, 16'h1133, 16'h1133, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Read/write collisions on address 4
    req_a(1'b1, 1'b1, 2'b11, 3'd4, 16'h0011); req_b(1'b0, 1'b0, 2'b00, 3'd0, 16'h0);
    step(16'h0000, 16'h0, 16'h0011, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    req_a(1'b1, 1'b1, 2'b11, 3'd4, 16'h0022); req_b(1'b1, 1'b0, 2'b00, 3'd4, 16'h0);
    step(16'h0011, 16'h0011, 16'h0022, 16'h0022, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    req_a(1'b1, 1'b0, 2'b00, 3'd4, 16'h0); req_b(1'b1, 1'b1, 2'b11, 3'd4, 16'h0033);
    step(16'h0022, 16'h0022, 16'h0033, 16'h0033, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Out-of-range accesses, including a same-address pair beyond DEPTH
    req_a(1'b1, 1'b1, 2'b11, 3'd7, 16'h00FF); req_b(1'b1, 1'b0, 2'b00, 3'd6, 16'h0);
    step(16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    req_a(1'b1, 1'b1, 2'b11, 3'd7, 16'h00FF); req_b(1'b1, 1'b1, 2'b11, 3'd7, 16'h1111);
    step(16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    req_a(1'b1, 1'b0, 2'b00, 3'd4, 16'h0); req_b(1'b1, 1'b0, 2'b00, 3'd1, 16'h0);
    step(16'h0033, 16'h0000, 16'h0033, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // A write with no byte enables returns a word but changes nothing
    req_a(1'b1, 1'b1, 2'b00, 3'd3, 16'hFFFF); req_b(1'b0, 1'b0, 2'b00, 3'd0, 16'h0);
    step(16'hBE34, 16'h0, 16'hBE34, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    req_a(1'b0, 1'b0, 2'b00, 3'd0, 16'h0); req_b(1'b1, 1'b0, 2'b00, 3'd3, 16'h0);
    step(16'h0, 16'hBE34, 16'h0, 16'hBE34, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Write then read-back next cycle, with a same-address read pair
    req_a(1'b1, 1'b1, 2'b11, 3'd2, 16'h0077); req_b(1'b0, 1'b0, 2'b00, 3'd0, 16'h0);
    step(16'h0000, 16'h0, 16'h0077, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    req_a(1'b1, 1'b0, 2'b00, 3'd2, 16'h0); req_b(1'b1, 1'b0, 2'b00, 3'd2, 16'h0);
    step(16'h0077, 16'h0077, 16'h0077, 16'h0077, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-traffic: pipeline flushed, full clear repeated, address 2 back to zero
    do_reset();
    run_clear();
    req_a(1'b1, 1'b0, 2'b00, 3'd2, 16'h0); req_b(1'b1, 1'b0, 2'b00, 3'd3, 16'h0);
    step(16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    req_a(1'b0, 1'b0, 2'b00, 3'd0, 16'h0); req_b(1'b0, 1'b0, 2'b00, 3'd0, 16'h0);
    step(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
